// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage:
// redirect kinds, FSM state encoding and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    REDIR_BRANCH = 2'b00,
    REDIR_JUMP   = 2'b01,
    REDIR_JR     = 2'b10,
    REDIR_NONE   = 2'b11
  } redir_kind_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Branch immediates count words; convert to a byte offset with sign extension.
  function automatic logic [31:0] sext_words(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target computation with a legality check against
// word alignment and the ROM address range.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        target_ok
);

  logic [31:0] seq_pc;

  assign seq_pc = redirect_pc + PC_STEP;

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    target = 32'h0;
    unique case (redir_kind_e'(redirect_kind))
      REDIR_BRANCH: target = seq_pc + sext_words(branch_imm);
      REDIR_JUMP:   target = {seq_pc[31:28], jump_idx, 2'b00};
      REDIR_JR:     target = jr_target;
      default:      target = 32'h0;
    endcase
  end

  assign target_ok = (target[1:0] == 2'b00) && (target[31:ADDR_W+2] == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// buffers one instruction toward decode with a valid/ready handshake.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          WRAP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [31:0]       redirect_pc,
  input  logic [15:0]       branch_imm,
  input  logic [25:0]       jump_idx,
  input  logic [31:0]       jr_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [31:0]       out_pc,
  output logic              halted,
  output logic              addr_err
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_inst_q, out_inst_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic              addr_err_q, addr_err_d;

  logic [31:0] target;
  logic        target_ok;
  logic        redirect_req;
  logic        last_word;
  logic        can_capture;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .redirect_kind(redirect_kind),
    .redirect_pc  (redirect_pc),
    .branch_imm   (branch_imm),
    .jump_idx     (jump_idx),
    .jr_target    (jr_target),
    .target       (target),
    .target_ok    (target_ok)
  );

  assign rom_addr     = pc_q[ADDR_W+1:2];
  assign redirect_req = redirect_valid && (redirect_kind != REDIR_NONE);
  assign last_word    = &pc_q[ADDR_W+1:2];
  // The buffer slot is free if empty or if its word leaves this cycle.
  assign can_capture  = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    addr_err_d  = addr_err_q;
    unique case (state_q)
      ST_RUN: begin
        if (redirect_req) begin
          // Flush: anything handshaking this cycle is already consumed downstream.
          out_valid_d = 1'b0;
          if (target_ok) begin
            pc_d = target;
          end else begin
            addr_err_d = 1'b1;
            state_d    = ST_HALT;
          end
        end else if (can_capture) begin
          out_valid_d = 1'b1;
          out_inst_d  = rom_data;
          out_pc_d    = pc_q;
          if (!last_word)   pc_d    = pc_q + PC_STEP;
          else if (WRAP_EN) pc_d    = '0;
          else              state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == ST_HALT);
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed plus randomized bench for inst_fetch_unit against a transaction-level
// model; a second instance with WRAP_EN=0 covers the end-of-ROM halt.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, rst0_n;
  logic [5:0]  rom_addr, rom_addr0;
  logic [31:0] rom_data, rom_data0;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_pc;
  logic [15:0] branch_imm;
  logic [25:0] jump_idx;
  logic [31:0] jr_target;
  logic        out_valid, out_ready, halted, addr_err;
  logic [31:0] out_inst, out_pc;
  logic        out_valid0, ready0, halted0, addr_err0;
  logic [31:0] out_inst0, out_pc0;

  logic [31:0] rom [64];

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [31:0] m_pc, m_inst, m_opc;
  bit          m_valid, m_halt, m_err;

  always #5 clk = ~clk;

  assign rom_data  = rom[rom_addr];
  assign rom_data0 = rom[rom_addr0];

  inst_fetch_unit #(.ADDR_W(6), .DATA_W(32), .RESET_PC(32'h0), .WRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_pc(redirect_pc), .branch_imm(branch_imm), .jump_idx(jump_idx),
    .jr_target(jr_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .halted(halted), .addr_err(addr_err)
  );

  inst_fetch_unit #(.ADDR_W(6), .DATA_W(32), .RESET_PC(32'h0), .WRAP_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .redirect_valid(1'b0), .redirect_kind(2'b00),
    .redirect_pc(32'h0), .branch_imm(16'h0), .jump_idx(26'h0),
    .jr_target(32'h0), .out_valid(out_valid0), .out_ready(ready0),
    .out_inst(out_inst0), .out_pc(out_pc0), .halted(halted0), .addr_err(addr_err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_opc = 32'h0;
    m_valid = 0; m_halt = 0; m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    32'(out_valid), 32'(m_valid));
    check({tag, ".inst"},     out_inst, m_inst);
    check({tag, ".pc"},       out_pc, m_opc);
    check({tag, ".halted"},   32'(halted), 32'(m_halt));
    check({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
    check({tag, ".rom_addr"}, 32'(rom_addr), m_pc / 4);
  endtask

  // One clock: predict from current inputs, take the edge, then compare at the falling edge.
  task automatic step(input string tag);
    logic [31:0] tgt, n_pc, n_inst, n_opc;
    bit n_valid, n_halt, n_err;
    n_pc = m_pc; n_inst = m_inst; n_opc = m_opc;
    n_valid = m_valid; n_halt = m_halt; n_err = m_err;
    tgt = 32'h0;
    if (!m_halt) begin
      if (redirect_valid && redirect_kind != 2'd3) begin
        case (redirect_kind)
          2'd0:    tgt = redirect_pc + 32'd4 + 32'(int'($signed(branch_imm)) * 4);
          2'd1:    tgt = ((redirect_pc + 32'd4) & 32'hF000_0000) | (32'(jump_idx) * 32'd4);
          default: tgt = jr_target;
        endcase
        n_valid = 0;
        if (tgt % 4 == 0 && tgt < 32'd256) n_pc = tgt;
        else begin n_err = 1; n_halt = 1; end
      end else if (!m_valid || out_ready) begin
        n_inst  = rom[m_pc / 4];
        n_opc   = m_pc;
        n_valid = 1;
        n_pc    = (m_pc + 32'd4) % 32'd256;
      end
    end else if (out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    m_pc = n_pc; m_inst = n_inst; m_opc = n_opc;
    m_valid = n_valid; m_halt = n_halt; m_err = n_err;
    @(negedge clk);
    check_all(tag);
  endtask

  // Called just after a falling edge; reset is asserted and released between edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) rom[k] = 32'h1000_0000 + k;
    rst_n = 1'b0; rst0_n = 1'b0; ready0 = 1'b0;
    redirect_valid = 1'b0; redirect_kind = 2'b00; redirect_pc = 32'h0;
    branch_imm = 16'h0; jump_idx = 26'h0; jr_target = 32'h0; out_ready = 1'b1;
    model_reset();
    #3 check_all("reset");

    // Sequential fetch from reset
    @(negedge clk) rst_n = 1'b1;
    step("seq0"); step("seq1"); step("seq2");
    check("seq_pc8", out_pc, 32'h8);

    // Stall three cycles, then resume with no skip or duplicate
    out_ready = 1'b0;
    step("stall0"); step("stall1"); step("stall2");
    out_ready = 1'b1;
    step("resume");
    check("resume_pc12", out_pc, 32'hC);

    // Backward branch while a word is buffered
    redirect_valid = 1'b1; redirect_kind = 2'b00; redirect_pc = 32'h10; branch_imm = 16'hFFFC;
    step("branch");
    redirect_valid = 1'b0;
    step("branch_fetch");
    check("branch_target", out_pc, 32'h4);

    // Jump to word 0x30
    redirect_valid = 1'b1; redirect_kind = 2'b01; redirect_pc = 32'h20; jump_idx = 26'h30;
    step("jump");
    redirect_valid = 1'b0;
    check("jump_rom_addr", 32'(rom_addr), 32'h30);
    step("jump_fetch");
    check("jump_target", out_pc, 32'hC0);

    // Run through the end of the ROM and wrap
    for (int i = 0; i < 40; i++) begin
      if (m_valid && m_opc == 32'hFC) break;
      step("wrap_run");
    end
    check("wrap_last", out_pc, 32'hFC);
    step("wrap");
    check("wrap_zero", out_pc, 32'h0);

    // Misaligned register jump halts with addr_err
    redirect_valid = 1'b1; redirect_kind = 2'b10; jr_target = 32'h102;
    step("jr_bad");
    redirect_valid = 1'b0;
    check("jr_bad_err", 32'(addr_err), 32'h1);
    check("jr_bad_halt", 32'(halted), 32'h1);
    redirect_valid = 1'b1; redirect_kind = 2'b01; redirect_pc = 32'h0; jump_idx = 26'h4;
    step("halt_redirect");
    redirect_valid = 1'b0;
    step("halt_idle");

    // Asynchronous reset in the middle of a stall
    async_reset("reset2");
    step("re0"); step("re1");
    out_ready = 1'b0;
    step("re_stall");
    check("pre_areset_valid", 32'(out_valid), 32'h1);
    async_reset("areset");
    check("areset_inst", out_inst, 32'h0);
    out_ready = 1'b1;
    step("refetch0");
    check("refetch_pc", out_pc, 32'h0);
    step("refetch1");

    // WRAP_EN=0 instance: halt after the last ROM word
    rst0_n = 1'b1; ready0 = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step("bg");
      check("nowrap_pc", out_pc0, 32'(k) * 32'd4);
      if (k == 62) check("nowrap_run", 32'(halted0), 32'h0);
    end
    check("nowrap_halted", 32'(halted0), 32'h1);
    check("nowrap_valid_last", 32'(out_valid0), 32'h1);
    check("nowrap_inst_last", out_inst0, 32'h1000_003F);
    ready0 = 1'b0;
    step("bg");
    check("nowrap_hold_valid", 32'(out_valid0), 32'h1);
    check("nowrap_hold_addr", 32'(rom_addr0), 32'h3F);
    ready0 = 1'b1;
    step("bg");
    check("nowrap_drain", 32'(out_valid0), 32'h0);
    step("bg");
    check("nowrap_idle_valid", 32'(out_valid0), 32'h0);
    check("nowrap_idle_pc", out_pc0, 32'hFC);
    check("nowrap_no_err", 32'(addr_err0), 32'h0);

    // Randomized traffic with random redirects of every kind
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        redirect_valid = 1'b1;
        redirect_kind  = 2'($urandom_range(0, 3));
        redirect_pc    = 32'($urandom_range(0, 63)) << 2;
        branch_imm     = 16'($urandom_range(0, 40)) - 16'd20;
        jump_idx       = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(0, 63));
        jr_target      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 511))
                                                     : (32'($urandom_range(0, 63)) << 2);
      end else begin
        redirect_valid = 1'b0;
      end
      step("rnd");
      if (m_halt && !m_valid && $urandom_range(0, 3) == 0) async_reset("rnd_reset");
    end
    redirect_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
